// File: rtl/pmod_switch_debounce_if.sv
// Switch/LED channel bundle for pmod_switch_debounce.
// The master side drives the raw pins and the mode bits.
// The slave side (the debouncer) returns level, edge pulses and LED drive.
interface pmod_switch_debounce_if #(
   parameter int unsigned N_CH = 8
);
   logic [N_CH-1:0] sw_in;
   logic [N_CH-1:0] mode;
   logic [N_CH-1:0] state;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] led;

   modport master (
      output sw_in, mode,
      input  state, rise, fall, led
   );

   modport slave (
      input  sw_in, mode,
      output state, rise, fall, led
   );
endinterface

// File: rtl/pmod_switch_debounce.sv
// N-channel PMOD switch front end: 2-flop sync, per-channel debounce,
// one-cycle rise/fall pulses and LED drive.
// Optional build macro PMOD_SW_TOGGLE_EN adds a per-channel toggle latch
// that drives the LED when that channel's mode bit is set.
module pmod_switch_debounce #(
   parameter int unsigned N_CH           = 8,
   parameter int unsigned CLK_HZ         = 12_000_000,
   parameter int unsigned DEBOUNCE_MS    = 10,
   parameter bit          SW_ACTIVE_LOW  = 1'b1,
   parameter bit          LED_ACTIVE_LOW = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   pmod_switch_debounce_if.slave bus
);

   localparam int unsigned DB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned DB     = (DB_RAW < 1) ? 1 : DB_RAW;
   localparam int unsigned CW     = $clog2(DB + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

   localparam logic [N_CH-1:0] SW_IDLE  = {N_CH{SW_ACTIVE_LOW}};
   localparam logic [N_CH-1:0] LED_OFF  = {N_CH{LED_ACTIVE_LOW}};

   logic [N_CH-1:0] sync1_q, sync2_q;
   logic [N_CH-1:0] act;
   logic [N_CH-1:0] state_q, state_d;
   logic [N_CH-1:0] rise_q, rise_d;
   logic [N_CH-1:0] fall_q, fall_d;
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cnt_d [N_CH];

   // Two-flop synchroniser; idle value is the open-switch pin level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= SW_IDLE;
         sync2_q <= SW_IDLE;
      end else begin
         sync1_q <= bus.sw_in;
         sync2_q <= sync1_q;
      end
   end

   assign act = sync2_q ^ SW_IDLE;

   // Per-channel debounce: accept a new level after DB consecutive differing cycles.
   always_comb begin
      state_d = state_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (act[i] == state_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = act[i];
            rise_d[i]  = act[i];
            fall_d[i]  = ~act[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Debounce state, counters and registered edge pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.state = state_q;
   assign bus.rise  = rise_q;
   assign bus.fall  = fall_q;

`ifdef PMOD_SW_TOGGLE_EN
   logic [N_CH-1:0] tog_q;

   // Toggle latch flips together with the accepted rise on mode-enabled channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tog_q <= '0;
      else        tog_q <= tog_q ^ (rise_d & bus.mode);
   end

   assign bus.led = ((bus.mode & tog_q) | (~bus.mode & state_q)) ^ LED_OFF;
`else
   logic [N_CH-1:0] unused_mode;
   assign unused_mode = bus.mode;
   assign bus.led     = state_q ^ LED_OFF;
`endif

endmodule
